// File: rtl/graph_max_aggregator.sv
// graph_max_aggregator: ReLU and per-channel max over a node's neighbour lane results.
// Each finished node feature vector is queued in a small FIFO. The FIFO backpressures the issuer through stall.
module graph_max_aggregator #(
    parameter  int OUTPUT_DIM     = 16,
    parameter  int PRECISION      = 8,
    parameter  int ZERO_POINT     = 0,
    parameter  int MUL_LATENCY    = 3,
    parameter  int NODE_W         = 16,
    parameter  int MAX_NEIGHBOURS = 32,
    localparam int DEPTH          = MUL_LATENCY + 2,
    localparam int CW             = $clog2(MAX_NEIGHBOURS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic [NODE_W-1:0]    in_node_id,
    input  logic [PRECISION-1:0] dot_result [OUTPUT_DIM],
    output logic                 stall,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PRECISION-1:0] out_features [OUTPUT_DIM],
    output logic [NODE_W-1:0]    out_node_id,
    output logic [CW-1:0]        out_count,
    output logic                 overflow_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] SAT = CW'(MAX_NEIGHBOURS);

    logic [MUL_LATENCY-1:0] r_dv;
    logic [MUL_LATENCY-1:0] r_dl;
    logic [NODE_W-1:0]      r_did [MUL_LATENCY];
    logic                   w_dv;
    logic                   w_dl;
    logic [NODE_W-1:0]      w_did;

    // The sideband shift register matches the lane latency, so the tap lines up with dot_result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dv <= '0;
            r_dl <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) r_did[i] <= '0;
        end else begin
            r_dv[0]  <= in_valid;
            r_dl[0]  <= in_valid & in_last;
            r_did[0] <= in_node_id;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                r_dv[i]  <= r_dv[i-1];
                r_dl[i]  <= r_dl[i-1];
                r_did[i] <= r_did[i-1];
            end
        end
    end

    assign w_dv  = r_dv[MUL_LATENCY-1];
    assign w_dl  = r_dl[MUL_LATENCY-1];
    assign w_did = r_did[MUL_LATENCY-1];

    logic [PRECISION-1:0] w_relu [OUTPUT_DIM];
    logic [PRECISION-1:0] w_max  [OUTPUT_DIM];
    logic [PRECISION-1:0] r_acc  [OUTPUT_DIM];
    logic                 r_first;
    logic [CW-1:0]        r_count;
    logic [CW-1:0]        w_cnt_n;

    if (ZERO_POINT == 0) begin : g_no_floor
        assign w_relu = dot_result;
    end else begin : g_floor
        localparam logic [PRECISION-1:0] ZP = PRECISION'(ZERO_POINT);
        always_comb begin
            for (int m = 0; m < OUTPUT_DIM; m++)
                w_relu[m] = (dot_result[m] < ZP) ? ZP : dot_result[m];
        end
    end

    always_comb begin
        for (int m = 0; m < OUTPUT_DIM; m++)
            w_max[m] = (r_first || (w_relu[m] > r_acc[m])) ? w_relu[m] : r_acc[m];
        if (r_first)
            w_cnt_n = CW'(1);
        else if (r_count >= SAT)
            w_cnt_n = SAT;
        else
            w_cnt_n = r_count + CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_first <= 1'b1;
            r_count <= '0;
            for (int m = 0; m < OUTPUT_DIM; m++) r_acc[m] <= '0;
        end else if (w_dv && !w_dl) begin
            r_acc   <= w_max;
            r_count <= w_cnt_n;
            r_first <= 1'b0;
        end else if (w_dv && w_dl) begin
            r_first <= 1'b1;
        end
    end

    logic [PRECISION-1:0] r_mem_f   [DEPTH][OUTPUT_DIM];
    logic [NODE_W-1:0]    r_mem_id  [DEPTH];
    logic [CW-1:0]        r_mem_cnt [DEPTH];
    logic [PRECISION-1:0] r_hold_f  [OUTPUT_DIM];
    logic [NODE_W-1:0]    r_hold_id;
    logic [CW-1:0]        r_hold_cnt;
    logic [PW-1:0]        r_wr;
    logic [PW-1:0]        r_rd;
    logic [OW-1:0]        r_occ;
    logic                 r_ovf;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_wr_en;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_push  = w_dv & w_dl;
    assign w_pop   = out_valid & out_ready;
    assign w_full  = (r_occ == OW'(DEPTH));
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign w_wr_en = w_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_f[r_wr]   <= w_max;
            r_mem_id[r_wr]  <= w_did;
            r_mem_cnt[r_wr] <= w_cnt_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_occ      <= '0;
            r_ovf      <= 1'b0;
            r_hold_id  <= '0;
            r_hold_cnt <= '0;
            for (int m = 0; m < OUTPUT_DIM; m++) r_hold_f[m] <= '0;
        end else begin
            if (w_wr_en) r_wr <= f_inc(r_wr);
            if (w_pop) begin
                r_rd       <= f_inc(r_rd);
                r_hold_f   <= r_mem_f[r_rd];
                r_hold_id  <= r_mem_id[r_rd];
                r_hold_cnt <= r_mem_cnt[r_rd];
            end
            if (w_wr_en && !w_pop)
                r_occ <= r_occ + OW'(1);
            else if (!w_wr_en && w_pop)
                r_occ <= r_occ - OW'(1);
            if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    assign out_valid    = (r_occ != '0);
    assign stall        = (r_occ >= OW'(2));
    assign overflow_err = r_ovf;

    // When the FIFO is empty, the outputs show the most recently popped entry.
    always_comb begin
        if (out_valid) begin
            out_features = r_mem_f[r_rd];
            out_node_id  = r_mem_id[r_rd];
            out_count    = r_mem_cnt[r_rd];
        end else begin
            out_features = r_hold_f;
            out_node_id  = r_hold_id;
            out_count    = r_hold_cnt;
        end
    end

endmodule

// File: tb/tb_graph_max_aggregator.sv
// Bench for graph_max_aggregator: table vectors, directed corner sequences and a
// randomized run scored against a node-level queue model.
module tb_graph_max_aggregator;
    localparam int D = 16, P = 8, L = 3, NW = 16, CW = 6;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [NW-1:0] in_node_id = '0;
    logic [P-1:0] issue_vals [D];
    logic [P-1:0] pipe0 [D], pipe1 [D], pipe2 [D];

    logic stall0, ov0, ovf0, stall1, ov1, ovf1;
    logic [P-1:0] feat0 [D], feat1 [D];
    logic [NW-1:0] id0, id1;
    logic [CW-1:0] cnt0, cnt1;

    int checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;

    // Lane model: operands issued with in_valid come back L cycles later.
    always @(posedge clk) begin
        pipe0 <= issue_vals;
        pipe1 <= pipe0;
        pipe2 <= pipe1;
    end

    graph_max_aggregator #(.ZERO_POINT(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
        .in_node_id(in_node_id), .dot_result(pipe2), .stall(stall0), .out_valid(ov0),
        .out_ready(out_ready), .out_features(feat0), .out_node_id(id0), .out_count(cnt0),
        .overflow_err(ovf0));

    graph_max_aggregator #(.ZERO_POINT(128)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
        .in_node_id(in_node_id), .dot_result(pipe2), .stall(stall1), .out_valid(ov1),
        .out_ready(out_ready), .out_features(feat1), .out_node_id(id1), .out_count(cnt1),
        .overflow_err(ovf1));

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack(input logic [P-1:0] f [D]);
        logic [127:0] v;
        for (int i = 0; i < D; i++) v[i*8 +: 8] = f[i];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_last = 1'($urandom);
        in_node_id = NW'($urandom);
        for (int i = 0; i < D; i++) issue_vals[i] = P'($urandom);
    endtask

    task automatic issue(input logic [NW-1:0] id, input logic last, input logic [P-1:0] l0,
                         input logic [P-1:0] l1);
        in_valid = 1'b1;
        in_last = last;
        in_node_id = id;
        issue_vals[0] = l0;
        issue_vals[1] = l1;
        for (int i = 2; i < D; i++) issue_vals[i] = '0;
        tick();
        idle_inputs();
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!ov0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!ov0) begin
            errors++;
            $display("FAIL %s: out_valid got 0 expected 1 within 20 cycles", name);
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [P-1:0] a, b, e0, e128;
    } vec_t;

    typedef struct packed {
        logic [127:0]   f;
        logic [NW-1:0]  id;
        logic [CW-1:0]  cnt;
        logic [31:0]    land;
    } ent_t;

    vec_t tbl [6];
    ent_t mq [$];
    ent_t pend [$];
    int cur_max [D];
    int cur_n;
    int n_iss;
    int mx;
    int c;
    logic [127:0] ev;
    ent_t e;
    logic lst;

    initial begin
        tbl[0] = '{8'd100, 8'd120, 8'd120, 8'd128};
        tbl[1] = '{8'd100, 8'd200, 8'd200, 8'd200};
        tbl[2] = '{8'd130, 8'd129, 8'd130, 8'd130};
        tbl[3] = '{8'd0,   8'd0,   8'd0,   8'd128};
        tbl[4] = '{8'd255, 8'd3,   8'd255, 8'd255};
        tbl[5] = '{8'd127, 8'd128, 8'd128, 8'd128};

        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        chk("rst_valid", ov0, 0);
        chk("rst_stall", stall0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_id", id0, 0);
        chk("rst_cnt", cnt0, 0);
        chk("rst_feat", pack(feat0), 0);

        // Node 7: three back-to-back neighbours, last issued in cycle c.
        issue(7, 0, 5, 0);
        issue(7, 0, 9, 0);
        c = cyc;
        issue(7, 1, 2, 4);
        tick();
        tick();
        chk("t1_not_before_c4", ov0, 0);
        tick();
        chk("t1_latency_c", cyc, c + 4);
        chk("t1_valid_c4", ov0, 1);
        ev = '0;
        ev[7:0] = 8'd9;
        ev[15:8] = 8'd4;
        chk("t1_feat", pack(feat0), ev);
        chk("t1_id", id0, 7);
        chk("t1_cnt", cnt0, 3);
        pop();
        chk("t1_empty", ov0, 0);

        // Two-neighbour nodes, ReLU floor at 0 and at 128.
        for (int i = 0; i < 6; i++) begin
            issue(NW'(20 + i), 0, tbl[i].a, 0);
            issue(NW'(20 + i), 1, tbl[i].b, 0);
            wait_valid("t2_wait");
            chk("t2_zp0_l0", feat0[0], tbl[i].e0);
            chk("t2_zp128_l0", feat1[0], tbl[i].e128);
            chk("t2_zp128_l1", feat1[1], 128);
            chk("t2_cnt", cnt1, 2);
            pop();
        end

        // Fill while obeying stall with the consumer blocked.
        out_ready = 1'b0;
        n_iss = 0;
        for (int k = 0; k < 15; k++) begin
            if (!stall0 && n_iss < 10) begin
                n_iss++;
                issue(NW'(n_iss), 1, P'(n_iss * 3), 0);
            end else begin
                tick();
            end
        end
        chk("t3_issued", n_iss, 5);
        chk("t3_stall", stall0, 1);
        chk("t3_ovf", ovf0, 0);
        chk("t3_valid", ov0, 1);
        chk("t3_head_id", id0, 1);

        // Full FIFO: a push lands in the same cycle as a pop.
        issue(6, 1, 18, 0);
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_ovf", ovf0, 0);
        chk("t4_head_id", id0, 2);
        for (int k = 2; k <= 6; k++) begin
            chk("t4_drain_id", id0, k);
            chk("t4_drain_l0", feat0[0], k * 3);
            chk("t4_drain_valid", ov0, 1);
            pop();
        end
        chk("t4_empty", ov0, 0);
        chk("t4_hold_id", id0, 6);
        chk("t4_ovf_end", ovf0, 0);

        // Randomized traffic against a node-level queue model.
        cur_n = 0;
        for (int k = 0; k < 700; k++) begin
            chk("rnd_valid", ov0, mq.size() != 0);
            chk("rnd_stall", stall0, mq.size() >= 2);
            if (mq.size() != 0) begin
                chk("rnd_id", id0, mq[0].id);
                chk("rnd_cnt", cnt0, mq[0].cnt);
                chk("rnd_feat", pack(feat0), mq[0].f);
            end
            if (k >= 640) out_ready = 1'b1;
            else if ((k % 200) < 70) out_ready = ($urandom_range(0, 3) == 0);
            else out_ready = ($urandom_range(0, 3) != 0);
            if (out_ready && mq.size() != 0) void'(mq.pop_front());
            if (!stall0 && (k < 600 || (cur_n != 0 && k < 630)) && $urandom_range(0, 3) != 0) begin
                lst = (k >= 600) || ($urandom_range(0, 2) == 0);
                in_valid = 1'b1;
                in_last = lst;
                in_node_id = NW'($urandom);
                for (int i = 0; i < D; i++) begin
                    issue_vals[i] = P'($urandom);
                    if (cur_n == 0 || int'(issue_vals[i]) > cur_max[i]) cur_max[i] = int'(issue_vals[i]);
                end
                cur_n++;
                if (lst) begin
                    for (int i = 0; i < D; i++) e.f[i*8 +: 8] = P'(cur_max[i]);
                    e.id = in_node_id;
                    e.cnt = CW'((cur_n > 32) ? 32 : cur_n);
                    e.land = 32'(cyc + L + 1);
                    pend.push_back(e);
                    cur_n = 0;
                end
            end else begin
                idle_inputs();
            end
            tick();
            while (pend.size() != 0 && pend[0].land == 32'(cyc)) mq.push_back(pend.pop_front());
        end
        idle_inputs();
        out_ready = 1'b0;
        chk("rnd_end_valid", ov0, 0);
        chk("rnd_end_ovf", ovf0, 0);

        // 40 neighbours: the count saturates at 32.
        mx = 0;
        for (int j = 0; j < 40; j++) begin
            c = (j == 17) ? 231 : $urandom_range(0, 200);
            if (c > mx) mx = c;
            issue(40, j == 39, P'(c), 0);
        end
        wait_valid("t5_wait");
        chk("t5_cnt_sat", cnt0, 32);
        chk("t5_max", feat0[0], mx);
        chk("t5_id", id0, 40);

        // Reset asserted mid-node, with a full-node entry still queued.
        issue(41, 0, 50, 0);
        issue(41, 0, 60, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rst_valid", ov0, 0);
        chk("t5_rst_feat", pack(feat0), 0);
        chk("t5_rst_id", id0, 0);
        chk("t5_rst_cnt", cnt0, 0);
        chk("t5_rst_stall", stall0, 0);
        chk("t5_rst_ovf", ovf0, 0);
        tick();
        reset = 1'b1;
        tick();
        issue(9, 0, 3, 0);
        issue(9, 1, 1, 0);
        wait_valid("t5_post_wait");
        chk("t5_post_l0", feat0[0], 3);
        chk("t5_post_cnt", cnt0, 2);
        chk("t5_post_id", id0, 9);
        pop();
        tick();
        chk("t5_post_empty", ov0, 0);

        // Stall ignored: 7 nodes into a 5-entry FIFO.
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) issue(NW'(11 + i), 1, P'(i + 1), 0);
        repeat (8) tick();
        chk("t6_ovf", ovf0, 1);
        repeat (5) tick();
        chk("t6_ovf_sticky", ovf0, 1);
        for (int k = 0; k < 5; k++) begin
            chk("t6_drain_id", id0, 11 + k);
            chk("t6_drain_l0", feat0[0], k + 1);
            pop();
        end
        chk("t6_empty", ov0, 0);
        chk("t6_ovf_end", ovf0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
